// File: rtl/usb3_lfps_tx.sv
// LFPS burst generator for the USB 3.0 device port: Polling, Ping, U-exit and
// Warm Reset bursts formed by toggling PIPE TxElecIdle with TxOnesZeros high.
module usb3_lfps_tx #(
  parameter int unsigned HALF_PERIOD = 3,
  parameter int unsigned POLL_BURST  = 125,
  parameter int unsigned POLL_REPEAT = 1250,
  parameter int unsigned PING_BURST  = 10,
  parameter int unsigned EXIT_MAX    = 250000,
  parameter int unsigned RESET_MIN   = 10000000
) (
  input  logic       local_clk,
  input  logic       reset_n,
  input  logic [2:0] send_mode,
  input  logic       send_go,
  input  logic       send_stop,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       lfps_active,
  output logic       tx_elecidle,
  output logic       tx_oneszeros,
  output logic [7:0] burst_count
);

  // state  | meaning
  // IDLE   | waiting for send_go with a valid mode
  // BURST  | LFPS burst on the line, tx_elecidle toggling
  // GAP    | polling inter-burst electrical idle
  // FINISH | one-cycle done (and timeout) pulse

  localparam int TOG_W = ($clog2(HALF_PERIOD) > 2) ? $clog2(HALF_PERIOD) : 2;
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(HALF_PERIOD - 1);

  localparam logic [23:0] POLL_LAST  = 24'(POLL_BURST - 1);
  localparam logic [23:0] GAP_LAST   = 24'(POLL_REPEAT - POLL_BURST - 1);
  localparam logic [23:0] PING_LAST  = 24'(PING_BURST - 1);
  localparam logic [23:0] EXIT_LAST  = 24'(EXIT_MAX - 1);
  localparam logic [23:0] RESET_LAST = 24'(RESET_MIN - 1);

  localparam logic [2:0] MODE_POLL  = 3'd1;
  localparam logic [2:0] MODE_PING  = 3'd2;
  localparam logic [2:0] MODE_UEXIT = 3'd3;
  localparam logic [2:0] MODE_WARM  = 3'd4;

  typedef enum logic [1:0] {IDLE, BURST, GAP, FINISH} state_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [23:0]      cyc_cnt;
  logic [23:0]      cyc_next;
  logic [TOG_W-1:0] tog_cnt;
  logic             stop_seen;
  logic             burst_end;
  logic             burst_fin;
  logic             burst_to;
  logic             go_ok;

  assign cyc_next = (cyc_cnt == 24'hFF_FFFF) ? cyc_cnt : cyc_cnt + 24'd1;
  assign go_ok    = send_go && (send_mode >= MODE_POLL) && (send_mode <= MODE_WARM);

  // burst_fin selects FINISH over GAP; burst_to only matters when burst_end is set
  always_comb begin
    burst_end = 1'b0;
    burst_fin = 1'b1;
    burst_to  = 1'b0;
    case (mode_q)
      MODE_POLL: begin
        burst_end = (cyc_cnt == POLL_LAST);
        burst_fin = stop_seen | send_stop;
      end
      MODE_PING:  burst_end = (cyc_cnt == PING_LAST);
      MODE_UEXIT: begin
        burst_end = send_stop | (cyc_cnt == EXIT_LAST);
        burst_to  = ~send_stop;
      end
      MODE_WARM:  burst_end = send_stop && (cyc_cnt >= RESET_LAST);
      default:    burst_end = 1'b1;
    endcase
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      mode_q       <= 3'd0;
      cyc_cnt      <= 24'd0;
      tog_cnt      <= '0;
      stop_seen    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      lfps_active  <= 1'b0;
      tx_elecidle  <= 1'b1;
      tx_oneszeros <= 1'b0;
      burst_count  <= 8'd0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (go_ok) begin
            mode_q       <= send_mode;
            burst_count  <= 8'd0;
            busy         <= 1'b1;
            state        <= BURST;
            cyc_cnt      <= 24'd0;
            tog_cnt      <= '0;
            stop_seen    <= 1'b0;
            lfps_active  <= 1'b1;
            tx_elecidle  <= 1'b0;
            tx_oneszeros <= 1'b1;
          end
        end
        BURST: begin
          cyc_cnt <= cyc_next;
          if (send_stop) stop_seen <= 1'b1;
          if (tog_cnt == TOG_LAST) begin
            tog_cnt     <= '0;
            tx_elecidle <= ~tx_elecidle;
          end else begin
            tog_cnt <= tog_cnt + 1'b1;
          end
          if (burst_end) begin
            lfps_active  <= 1'b0;
            tx_elecidle  <= 1'b1;
            tx_oneszeros <= 1'b0;
            cyc_cnt      <= 24'd0;
            tog_cnt      <= '0;
            if (mode_q == MODE_POLL && burst_count != 8'hFF)
              burst_count <= burst_count + 8'd1;
            if (burst_fin) begin
              state   <= FINISH;
              done    <= 1'b1;
              timeout <= burst_to;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          cyc_cnt <= cyc_next;
          if (send_stop) begin
            state   <= FINISH;
            done    <= 1'b1;
            cyc_cnt <= 24'd0;
          end else if (cyc_cnt == GAP_LAST) begin
            state        <= BURST;
            cyc_cnt      <= 24'd0;
            tog_cnt      <= '0;
            stop_seen    <= 1'b0;
            lfps_active  <= 1'b1;
            tx_elecidle  <= 1'b0;
            tx_oneszeros <= 1'b1;
          end
        end
        FINISH: begin
          state   <= IDLE;
          busy    <= 1'b0;
          cyc_cnt <= 24'd0;
          tog_cnt <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb3_lfps_tx.sv
// Bench for usb3_lfps_tx: a monitor measures bursts, start-to-start periods and
// done pulses, and compares each against expectations queued by the stimulus.
module tb_usb3_lfps_tx;

  logic       local_clk = 1'b0;
  logic       reset_n;
  logic [2:0] send_mode;
  logic       send_go;
  logic       send_stop;
  logic       busy, done, timeout, lfps_active, tx_elecidle, tx_oneszeros;
  logic [7:0] burst_count;

  int n_tests = 0;
  int n_fail  = 0;

  string sb_tag[$];
  int    sb_val[$];

  int mon_cyc, rise_cyc, run_len;
  bit have_rise, lfps_prev;

  usb3_lfps_tx #(
    .HALF_PERIOD(3), .POLL_BURST(125), .POLL_REPEAT(1250),
    .PING_BURST(10), .EXIT_MAX(2000), .RESET_MIN(1000)
  ) dut (
    .local_clk(local_clk), .reset_n(reset_n), .send_mode(send_mode),
    .send_go(send_go), .send_stop(send_stop), .busy(busy), .done(done),
    .timeout(timeout), .lfps_active(lfps_active), .tx_elecidle(tx_elecidle),
    .tx_oneszeros(tx_oneszeros), .burst_count(burst_count)
  );

  always #4 local_clk = ~local_clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_pop(input string tag, input int val);
    string t;
    int    v;
    if (sb_tag.size() == 0) begin
      chk_eq({"unexpected_", tag}, 32'(val), 32'hDEAD_BEEF);
      return;
    end
    t = sb_tag.pop_front();
    v = sb_val.pop_front();
    if (t != tag) chk_eq({"order_", t, "_got_", tag}, 32'(val), 32'hDEAD_BEEF);
    else          chk_eq(tag, 32'(val), 32'(v));
  endtask

  always @(negedge local_clk) begin
    if (!reset_n) begin
      have_rise = 1'b0;
      lfps_prev = 1'b0;
      run_len   = 0;
    end else begin
      mon_cyc++;
      if (lfps_active && !lfps_prev) begin
        if (have_rise) sb_pop("period", mon_cyc - rise_cyc);
        rise_cyc  = mon_cyc;
        have_rise = 1'b1;
        run_len   = 0;
      end
      if (lfps_active) run_len++;
      if (!lfps_active && lfps_prev) sb_pop("burst_len", run_len);
      if (done) begin
        sb_pop("timeout", int'(timeout));
        sb_pop("bcnt", int'(burst_count));
        have_rise = 1'b0;
      end
      lfps_prev = lfps_active;
    end
  end

  // go strobe for one cycle; returns on the negedge just after it was sampled
  task automatic send(input logic [2:0] m);
    @(negedge local_clk);
    send_mode = m;
    send_go   = 1'b1;
    @(negedge local_clk);
    send_go   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge local_clk);
      n++;
    end
    chk_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int pat[10] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    reset_n   = 1'b1;
    send_mode = 3'd0;
    send_go   = 1'b0;
    send_stop = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge local_clk);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_done", 32'(done), 32'd0);
    chk_eq("rst_timeout", 32'(timeout), 32'd0);
    chk_eq("rst_lfps", 32'(lfps_active), 32'd0);
    chk_eq("rst_elecidle", 32'(tx_elecidle), 32'd1);
    chk_eq("rst_oneszeros", 32'(tx_oneszeros), 32'd0);
    chk_eq("rst_bcnt", 32'(burst_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge local_clk);

    // Ping with a go mid-burst and another on the FINISH cycle, both ignored
    sb_push("burst_len", 10); sb_push("timeout", 0); sb_push("bcnt", 0);
    send(3'd2);
    for (int k = 0; k < 10; k++) begin
      chk_eq($sformatf("ping_lfps_%0d", k), 32'(lfps_active), 32'd1);
      chk_eq($sformatf("ping_ei_%0d", k), 32'(tx_elecidle), 32'(pat[k]));
      chk_eq($sformatf("ping_oz_%0d", k), 32'(tx_oneszeros), 32'd1);
      send_go = (k == 4);
      send_mode = 3'd1;
      @(negedge local_clk);
    end
    send_go = 1'b0;
    chk_eq("ping_end_lfps", 32'(lfps_active), 32'd0);
    chk_eq("ping_end_ei", 32'(tx_elecidle), 32'd1);
    chk_eq("ping_done", 32'(done), 32'd1);
    chk_eq("ping_busy_fin", 32'(busy), 32'd1);
    send_mode = 3'd2;
    send_go   = 1'b1;
    @(negedge local_clk);
    send_go = 1'b0;
    chk_eq("ping_busy_after", 32'(busy), 32'd0);
    chk_eq("ping_done_after", 32'(done), 32'd0);
    @(negedge local_clk);
    chk_eq("fin_go_ignored", 32'(busy), 32'd0);

    // Reserved mode
    send(3'd6);
    chk_eq("mode6_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge local_clk);
    chk_eq("mode6_busy_late", 32'(busy), 32'd0);
    chk_eq("mode6_lfps", 32'(lfps_active), 32'd0);

    // Polling, stop in the gap after the second burst
    sb_push("burst_len", 125); sb_push("period", 1250); sb_push("burst_len", 125);
    sb_push("timeout", 0); sb_push("bcnt", 2);
    send(3'd1);
    repeat (1874) @(negedge local_clk);
    send_stop = 1'b1;
    @(negedge local_clk);
    chk_eq("poll_gap_stop_done", 32'(done), 32'd1);
    send_stop = 1'b0;
    wait_idle("poll1", 20);
    repeat (5) @(negedge local_clk);
    chk_eq("poll_bcnt_hold", 32'(burst_count), 32'd2);

    // Polling, stop mid third burst: that burst still runs in full
    sb_push("burst_len", 125); sb_push("period", 1250); sb_push("burst_len", 125);
    sb_push("period", 1250); sb_push("burst_len", 125);
    sb_push("timeout", 0); sb_push("bcnt", 3);
    send(3'd1);
    chk_eq("poll2_bcnt_clr", 32'(burst_count), 32'd0);
    repeat (2549) @(negedge local_clk);
    send_stop = 1'b1;
    wait_idle("poll2", 200);
    send_stop = 1'b0;

    // U-exit stopped by the LTSSM
    sb_push("burst_len", 499); sb_push("timeout", 0); sb_push("bcnt", 0);
    send(3'd3);
    repeat (498) @(negedge local_clk);
    send_stop = 1'b1;
    wait_idle("uexit_stop", 20);
    send_stop = 1'b0;

    // U-exit timeout
    sb_push("burst_len", 2000); sb_push("timeout", 1); sb_push("bcnt", 0);
    send(3'd3);
    wait_idle("uexit_to", 2100);

    // U-exit stop on the EXIT_MAX cycle is a normal stop
    sb_push("burst_len", 2000); sb_push("timeout", 0); sb_push("bcnt", 0);
    send(3'd3);
    repeat (1999) @(negedge local_clk);
    send_stop = 1'b1;
    wait_idle("uexit_edge", 20);
    send_stop = 1'b0;

    // Warm Reset with stop high from the start
    sb_push("burst_len", 1000); sb_push("timeout", 0); sb_push("bcnt", 0);
    send(3'd4);
    send_stop = 1'b1;
    wait_idle("warm", 1100);
    send_stop = 1'b0;

    // Reset mid polling burst acts asynchronously
    send(3'd1);
    repeat (60) @(negedge local_clk);
    @(posedge local_clk);
    #2 reset_n = 1'b0;
    #1;
    chk_eq("async_ei", 32'(tx_elecidle), 32'd1);
    chk_eq("async_lfps", 32'(lfps_active), 32'd0);
    chk_eq("async_oz", 32'(tx_oneszeros), 32'd0);
    chk_eq("async_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge local_clk);
    reset_n = 1'b1;
    @(negedge local_clk);
    chk_eq("post_rst_bcnt", 32'(burst_count), 32'd0);

    sb_push("burst_len", 10); sb_push("timeout", 0); sb_push("bcnt", 0);
    send(3'd2);
    chk_eq("post_rst_busy", 32'(busy), 32'd1);
    wait_idle("post_rst_ping", 30);

    repeat (3) @(negedge local_clk);
    chk_eq("sb_empty", 32'(sb_tag.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
